// File: rtl/imem_fill_ctrl.sv
// Instruction-line fill controller: holds one 4-word line and its tag,
// and fetches a new line on a miss with a four-beat memory burst.
module imem_fill_ctrl #(
  parameter int ADDR_LEN = 32,
  parameter int INSN_LEN = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_LEN-1:0]   pc,
  input  logic                  fetch_req,
  input  logic                  redirect,
  input  logic                  inv,
  output logic                  line_valid,
  output logic [4*INSN_LEN-1:0] idata,
  output logic                  mem_req,
  output logic [ADDR_LEN-1:0]   mem_addr,
  input  logic                  mem_ack,
  input  logic                  mem_rvalid,
  input  logic [INSN_LEN-1:0]   mem_rdata
);

  localparam int TW = ADDR_LEN - 4;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    FILL
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          beat_cnt_q, beat_cnt_d;
  logic                drop_q, drop_d;
  logic                valid_q, valid_d;
  logic [TW-1:0]       tag_q, tag_d;
  logic [ADDR_LEN-1:0] addr_q, addr_d;
  logic [INSN_LEN-1:0] line_q [4];
  logic [INSN_LEN-1:0] line_d [4];
  logic                hit;

  assign hit        = valid_q && (tag_q == pc[ADDR_LEN-1:4]);
  assign line_valid = hit;
  assign idata      = {line_q[3], line_q[2], line_q[1], line_q[0]};
  assign mem_req    = (state_q == REQ);
  assign mem_addr   = addr_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      beat_cnt_q <= 2'd0;
      drop_q     <= 1'b0;
      valid_q    <= 1'b0;
      tag_q      <= '0;
      addr_q     <= '0;
      for (int k = 0; k < 4; k++) line_q[k] <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      drop_q     <= drop_d;
      valid_q    <= valid_d;
      tag_q      <= tag_d;
      addr_q     <= addr_d;
      for (int k = 0; k < 4; k++) line_q[k] <= line_d[k];
    end
  end

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    drop_d     = drop_q;
    valid_d    = valid_q;
    tag_d      = tag_q;
    addr_d     = addr_q;
    for (int k = 0; k < 4; k++) line_d[k] = line_q[k];
    unique case (state_q)
      IDLE: begin
        if (inv) valid_d = 1'b0;
        if (fetch_req && !hit && !redirect) begin
          state_d = REQ;
          addr_d  = {pc[ADDR_LEN-1:4], 4'b0000};
          tag_d   = pc[ADDR_LEN-1:4];
          valid_d = 1'b0;
          drop_d  = 1'b0;
        end
      end
      REQ: begin
        if (redirect || inv) drop_d = 1'b1;
        if (mem_ack) begin
          state_d    = FILL;
          beat_cnt_d = 2'd0;
        end
      end
      FILL: begin
        if (redirect || inv) drop_d = 1'b1;
        // A stale burst still lands its data; only validation is suppressed
        if (mem_rvalid) begin
          line_d[beat_cnt_q] = mem_rdata;
          beat_cnt_d         = beat_cnt_q + 2'd1;
          if (beat_cnt_q == 2'd3) begin
            state_d = IDLE;
            valid_d = !drop_q && !inv;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_imem_fill_ctrl.sv
// Self-checking bench for imem_fill_ctrl: per-cycle vectors with
// expected outputs queued at drive time and checked before the edge.
module tb_imem_fill_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  pc;
  logic         fetch_req, redirect, inv;
  logic         line_valid;
  logic [127:0] idata;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_ack, mem_rvalid;
  logic [31:0]  mem_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  imem_fill_ctrl #(.ADDR_LEN(32), .INSN_LEN(32)) dut (
    .clk(clk), .reset(reset), .pc(pc),
    .fetch_req(fetch_req), .redirect(redirect), .inv(inv),
    .line_valid(line_valid), .idata(idata),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic         rst_n;
    logic [31:0]  pc;
    logic         fr, rd, iv, ak, rv;
    logic [31:0]  dat;
    logic         chk;
    logic         elv, erq;
    logic         ca;
    logic [31:0]  eaddr;
    logic         cd;
    logic [127:0] eid;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];

  function automatic vec_t mk(
    input logic rst_n, input logic [31:0] p,
    input logic fr, input logic rd, input logic iv,
    input logic ak, input logic rv, input logic [31:0] dat,
    input logic chk, input logic elv, input logic erq,
    input logic ca, input logic [31:0] ea,
    input logic cd, input logic [127:0] eid);
    vec_t v;
    v.rst_n = rst_n; v.pc = p; v.fr = fr; v.rd = rd;
    v.iv = iv; v.ak = ak; v.rv = rv; v.dat = dat;
    v.chk = chk; v.elv = elv; v.erq = erq;
    v.ca = ca; v.eaddr = ea; v.cd = cd; v.eid = eid;
    return v;
  endfunction

  task automatic cmp1(input string nm, input logic a, input logic e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", nm, a, e);
    end
  endtask

  task automatic step(input vec_t v, input string nm);
    vec_t e;
    @(negedge clk);
    reset = v.rst_n; pc = v.pc; fetch_req = v.fr;
    redirect = v.rd; inv = v.iv; mem_ack = v.ak;
    mem_rvalid = v.rv; mem_rdata = v.dat;
    exp_q.push_back(v);
    #1;
    e = exp_q.pop_front();
    if (e.chk) begin
      cmp1({nm, ".line_valid"}, line_valid, e.elv);
      cmp1({nm, ".mem_req"}, mem_req, e.erq);
    end
    if (e.ca) begin
      n_cmp++;
      if (mem_addr !== e.eaddr) begin
        n_bad++;
        $display("FAIL %s.mem_addr: got %h want %h",
                 nm, mem_addr, e.eaddr);
      end
    end
    if (e.cd) begin
      n_cmp++;
      if (idata !== e.eid) begin
        n_bad++;
        $display("FAIL %s.idata: got %h want %h", nm, idata, e.eid);
      end
    end
  endtask

  // shorthand: run cycle, check line_valid/mem_req (+addr when ca)
  task automatic cyc(input logic [31:0] p, input logic fr,
                     input logic rd, input logic iv, input logic ak,
                     input logic rv, input logic [31:0] dat,
                     input logic elv, input logic erq,
                     input logic ca, input logic [31:0] ea,
                     input string nm);
    step(mk(1, p, fr, rd, iv, ak, rv, dat, 1, elv, erq, ca, ea,
            0, '0), nm);
  endtask

  localparam logic [127:0] LA = 128'h000000A3_000000A2_000000A1_000000A0;
  localparam logic [127:0] LB = 128'h000000B3_000000B2_000000B1_000000B0;
  localparam logic [127:0] LC = 128'h000000C3_000000C2_000000C1_000000C0;

  initial begin
    reset = 0; pc = 0; fetch_req = 0; redirect = 0; inv = 0;
    mem_ack = 0; mem_rvalid = 0; mem_rdata = 0;

    // reset, then cold miss, hit, re-miss with delayed ack and gaps
    tbl.push_back(mk(0, 0, 0,0,0,0,0, 0, 0, 0,0, 0,0, 0,'0));
    tbl.push_back(mk(0, 0, 0,0,0,0,0, 0, 0, 0,0, 0,0, 0,'0));
    tbl.push_back(mk(1, 0, 0,0,0,0,0, 0, 1, 0,0, 1,0, 1,'0));
    tbl.push_back(mk(1, 32'h1008, 1,0,0,0,0, 0, 1, 0,0, 0,0, 0,'0));
    tbl.push_back(mk(1, 32'h1008, 1,0,0,1,0, 0, 1, 0,1, 1,32'h1000, 0,'0));
    tbl.push_back(mk(1, 32'h1008, 1,0,0,0,1, 32'hA0, 1, 0,0, 0,0, 0,'0));
    tbl.push_back(mk(1, 32'h1008, 1,0,0,0,1, 32'hA1, 1, 0,0, 0,0, 0,'0));
    tbl.push_back(mk(1, 32'h1008, 1,0,0,0,1, 32'hA2, 1, 0,0, 0,0, 0,'0));
    tbl.push_back(mk(1, 32'h1008, 1,0,0,0,1, 32'hA3, 1, 0,0, 0,0, 0,'0));
    tbl.push_back(mk(1, 32'h1008, 1,0,0,0,0, 0, 1, 1,0, 0,0, 1,LA));
    tbl.push_back(mk(1, 32'h100C, 1,0,0,0,0, 0, 1, 1,0, 0,0, 0,'0));
    tbl.push_back(mk(1, 32'h1010, 1,0,0,0,0, 0, 1, 0,0, 0,0, 0,'0));
    tbl.push_back(mk(1, 32'h1010, 1,0,0,0,0, 0, 1, 0,1, 1,32'h1010, 0,'0));
    tbl.push_back(mk(1, 32'h1010, 1,0,0,0,0, 0, 1, 0,1, 1,32'h1010, 0,'0));
    tbl.push_back(mk(1, 32'h1010, 1,0,0,0,0, 0, 1, 0,1, 1,32'h1010, 0,'0));
    tbl.push_back(mk(1, 32'h1010, 1,0,0,1,0, 0, 1, 0,1, 1,32'h1010, 0,'0));
    tbl.push_back(mk(1, 32'h1010, 1,0,0,0,1, 32'hB0, 1, 0,0, 0,0, 0,'0));
    tbl.push_back(mk(1, 32'h1010, 1,0,0,0,0, 0, 1, 0,0, 0,0, 0,'0));
    tbl.push_back(mk(1, 32'h1010, 1,0,0,0,1, 32'hB1, 1, 0,0, 0,0, 0,'0));
    tbl.push_back(mk(1, 32'h1010, 1,0,0,0,0, 0, 1, 0,0, 0,0, 0,'0));
    tbl.push_back(mk(1, 32'h1010, 1,0,0,0,1, 32'hB2, 1, 0,0, 0,0, 0,'0));
    tbl.push_back(mk(1, 32'h1010, 1,0,0,0,0, 0, 1, 0,0, 0,0, 0,'0));
    tbl.push_back(mk(1, 32'h1010, 1,0,0,0,1, 32'hB3, 1, 0,0, 0,0, 0,'0));
    tbl.push_back(mk(1, 32'h1010, 1,0,0,0,0, 0, 1, 1,0, 0,0, 1,LB));
    tbl.push_back(mk(1, 32'h1008, 0,0,0,0,0, 0, 1, 0,0, 0,0, 0,'0));

    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i], $sformatf("vec%0d", i));

    // redirect mid-fill: data lands, line stays invalid
    cyc(32'h2000, 1,0,0,0,0, 0, 0,0, 0,0, "rd_miss");
    cyc(32'h2000, 1,0,0,1,0, 0, 0,1, 1,32'h2000, "rd_ack");
    cyc(32'h2000, 1,0,0,0,1, 32'hC0, 0,0, 0,0, "rd_b0");
    cyc(32'h2000, 1,0,0,0,1, 32'hC1, 0,0, 0,0, "rd_b1");
    cyc(32'h3000, 1,1,0,0,0, 0, 0,0, 0,0, "rd_pulse");
    cyc(32'h3000, 1,0,0,0,1, 32'hC2, 0,0, 0,0, "rd_b2");
    cyc(32'h3000, 1,0,0,0,1, 32'hC3, 0,0, 0,0, "rd_b3");
    step(mk(1, 32'h2000, 0,0,0,0,0, 0, 1, 0,0, 0,0, 1,LC),
         "rd_stale");
    cyc(32'h3000, 1,0,0,0,0, 0, 0,0, 0,0, "new_miss");
    cyc(32'h3000, 1,0,0,1,0, 0, 0,1, 1,32'h3000, "new_req");
    for (int b = 0; b < 4; b++)
      cyc(32'h3000, 1,0,0,0,1, 32'hD0 + b, 0,0, 0,0, "new_beat");
    cyc(32'h3004, 1,0,0,0,0, 0, 1,0, 0,0, "new_hit");

    // invalidate in IDLE, refill starts, then reset mid-burst
    cyc(32'h3004, 1,0,1,0,0, 0, 1,0, 0,0, "inv_pulse");
    cyc(32'h3004, 1,0,0,0,0, 0, 0,0, 0,0, "inv_after");
    cyc(32'h3004, 1,0,0,1,0, 0, 0,1, 1,32'h3000, "inv_refill");
    cyc(32'h3004, 1,0,0,0,1, 32'hE0, 0,0, 0,0, "rst_b0");
    cyc(32'h3004, 1,0,0,0,1, 32'hE1, 0,0, 0,0, "rst_b1");
    step(mk(0, 32'h3004, 1,0,0,0,0, 0, 0, 0,0, 0,0, 0,'0), "rst");
    step(mk(1, 32'h3004, 0,0,0,0,0, 0, 1, 0,0, 1,0, 1,'0),
         "rst_after");

    // redirect in IDLE blocks a miss
    cyc(32'h4000, 1,1,0,0,0, 0, 0,0, 0,0, "idle_rd");
    cyc(32'h4000, 0,0,0,0,0, 0, 0,0, 0,0, "idle_rd_nomiss");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_fill_ctrl.md
# imem_fill_ctrl

Instruction-line fill controller for the fetch stage. It holds one 128-bit instruction line (four 32-bit words) and the line's tag. It drives the `idata` bus consumed by the fetch/select logic. On a miss it sequences a four-beat burst read from the external instruction memory port. Mispredict redirects and line invalidation are handled without violating the memory handshake.

## Interface
Parameters:
- ADDR_LEN, 32, byte address width; line tag is `pc[ADDR_LEN-1:4]`.
- INSN_LEN, 32, instruction/beat width; line = 4*INSN_LEN bits.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low; sampled on rising edge of clk.
- pc  in  ADDR_LEN  current fetch PC.
- fetch_req  in  1  fetch stage wants the line for `pc` this cycle.
- redirect  in  1  pipeline flush (prmiss); any in-flight fill becomes stale.
- inv  in  1  invalidate the held line (fence.i).
- line_valid  out  1  `idata` holds the line containing `pc`.
- idata  out  4*INSN_LEN  held line; word k in bits [32k+31:32k].
- mem_req  out  1  burst request to instruction memory.
- mem_addr  out  ADDR_LEN  line-aligned burst address; low 4 bits are zero.
- mem_ack  in  1  request accepted; valid only while mem_req=1.
- mem_rvalid  in  1  read beat valid.
- mem_rdata  in  INSN_LEN  read beat data; beats arrive in word order 0,1,2,3.

## Operation
- Registers:
  - buf[0..3]: the line words.
  - tag: ADDR_LEN-4 bits.
  - valid.
  - state: IDLE, REQ, FILL.
  - beat_cnt: 2 bits.
  - drop: 1 bit.
- hit = valid & (tag == pc[ADDR_LEN-1:4]). line_valid = hit, combinational from registers and `pc`. `idata` = {buf[3],buf[2],buf[1],buf[0]} at all times.
- IDLE:
  - fetch_req & !hit & !redirect → REQ.
  - On that transition, latch mem_addr = {pc[ADDR_LEN-1:4],4'b0} and tag ← pc[ADDR_LEN-1:4], and clear valid and drop.
- REQ:
  - mem_req=1 and mem_addr held stable until mem_ack=1. The request is never withdrawn.
  - mem_ack → FILL with beat_cnt=0.
- FILL:
  - Each mem_rvalid writes buf[beat_cnt] ← mem_rdata, then beat_cnt+1 (2-bit wrap).
  - On the beat with beat_cnt==3: go to IDLE, and set valid ← !drop & !inv.
  - mem_rvalid outside FILL is ignored.
- redirect in REQ or FILL sets drop=1. The burst completes normally and its data is written, but valid stays 0. The controller then returns to IDLE and re-evaluates the new `pc` the following cycle.
- redirect in IDLE has no state effect. A miss is not started in a cycle where redirect=1.
- inv:
  - In IDLE, clears valid.
  - In REQ/FILL, sets drop. The line in fill is never validated.
- Simultaneous mem_ack and mem_rvalid in REQ: the beat is ignored. The memory must not return a beat in the ack cycle.
- Reset overrides everything, including mid-burst. The memory side is responsible for discarding outstanding beats after reset.

## Timing
- Reset values:
  - state=IDLE, valid=0, drop=0, beat_cnt=0.
  - mem_req=0, mem_addr=0, tag=0, buf[*]=0.
  - Hence line_valid=0 and idata=0.
- Hit: line_valid in the same cycle `pc` is presented; zero latency.
- Miss, minimum latency (cycle 0 = miss seen in IDLE):
  - cycle 1: mem_req=1, mem_ack=1.
  - cycles 2–5: beats 0–3.
  - cycle 6: line_valid=1.
  - Total: 6 cycles.
- Gaps between beats (mem_rvalid low) stall beat_cnt and extend FILL with no limit.
- mem_req is high exactly for cycles in REQ. It drops in the cycle after mem_ack is sampled.
- At most one burst is outstanding at any time.

## Test plan
- Reset mid-burst: reset low during FILL after 2 beats → next cycle state IDLE, mem_req=0, line_valid=0, idata=0.
- Cold miss: pc=0x1008, fetch_req=1 → mem_req in cycle 1 with mem_addr=0x1000. Ack in cycle 1; beats 0xA0,0xA1,0xA2,0xA3 in cycles 2–5. Cycle 6: line_valid=1, idata=0x000000A3_000000A2_000000A1_000000A0.
- Hit and re-miss: after the cold miss, pc=0x100C → line_valid=1 same cycle, no mem_req. pc=0x1010 → line_valid=0 and mem_req with mem_addr=0x1010 next cycle.
- Delayed ack and beat gaps: mem_ack withheld 3 cycles → mem_req and mem_addr stable all 3 cycles. Beats with 1-cycle gaps → all 4 words land in order, line_valid after the last beat.
- Redirect mid-fill: redirect pulse after beat 1 of a fill for 0x2000, pc then 0x3000 → burst completes, valid stays 0. A new mem_req for 0x3000 issues 2 cycles after beat 3.
- Invalidate: inv pulse in IDLE with a valid line → line_valid=0 next cycle for the same pc, and a new fill starts if fetch_req=1.
